// File: rtl/motion_pkg.sv
// Motion command encoding shared by both ends of the FPGA-Arduino link
// (this transmitter and the manual_mode decoder).
package motion_pkg;

  typedef enum logic [3:0] {
    Stop,
    Forward,
    Backward,
    Left,
    Right,
    Left_forward,
    Right_forward,
    Left_backward,
    Right_backward
  } dir_t;

  localparam logic [7:0] CMD_STOP           = 8'h00;
  localparam logic [7:0] CMD_FORWARD        = 8'h01;
  localparam logic [7:0] CMD_BACKWARD       = 8'h04;
  localparam logic [7:0] CMD_LEFT           = 8'h02;
  localparam logic [7:0] CMD_RIGHT          = 8'h08;
  localparam logic [7:0] CMD_LEFT_FORWARD   = 8'h03;
  localparam logic [7:0] CMD_RIGHT_FORWARD  = 8'h09;
  localparam logic [7:0] CMD_LEFT_BACKWARD  = 8'h06;
  localparam logic [7:0] CMD_RIGHT_BACKWARD = 8'h0C;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic [7:0] dir_to_cmd(input dir_t dir);
    case (dir)
      Forward:        return CMD_FORWARD;
      Backward:       return CMD_BACKWARD;
      Left:           return CMD_LEFT;
      Right:          return CMD_RIGHT;
      Left_forward:   return CMD_LEFT_FORWARD;
      Right_forward:  return CMD_RIGHT_FORWARD;
      Left_backward:  return CMD_LEFT_BACKWARD;
      Right_backward: return CMD_RIGHT_BACKWARD;
      default:        return CMD_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter: START/DATA/STOP FSM with a per-bit baud counter.
// The data byte is captured on start and held unchanged for the whole frame.
module uart_tx_8n1
  import motion_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);
  assign busy    = (state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      baud_cnt <= (state == TX_IDLE || bit_end) ? '0 : baud_cnt + CNT_W'(1);
      case (state)
        TX_IDLE: begin
          if (start) begin
            state <= TX_START;
            shreg <= data;
            tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state <= TX_DATA;
            tx    <= shreg[0];
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shreg[bit_idx + 3'd1];
            end
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            state <= TX_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motion_cmd_tx.sv
// Encodes the drive direction into a motion command byte and sends it over UART 8N1
// whenever it changes. Define MOTION_TX_HEARTBEAT_EN to also resend it periodically.
module motion_cmd_tx
  import motion_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int HEARTBEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w,
  input  logic       s,
  input  logic       a,
  input  logic       d,
  input  logic       wa,
  input  logic       wd,
  input  logic       as,
  input  logic       sd,
  output logic       uart_tx,
  output logic       busy,
  output logic       tx_done,
  output logic [7:0] sent_cmd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  if (CLKS_PER_BIT < 2 || HEARTBEAT_MS < 1) begin : g_bad_cfg
    $error("motion_cmd_tx: CLK_FREQ/BAUD must be >= 2 and HEARTBEAT_MS >= 1");
  end

  dir_t       dir;
  logic [7:0] cmd_q;
  logic [7:0] last_cmd;
  logic [7:0] sent_q;
  logic       start;
  logic       hb_fire;

  always_comb begin
    dir = Stop;
    if      (w)  dir = Forward;
    else if (s)  dir = Backward;
    else if (a)  dir = Left;
    else if (d)  dir = Right;
    else if (wa) dir = Left_forward;
    else if (wd) dir = Right_forward;
    else if (as) dir = Left_backward;
    else if (sd) dir = Right_backward;
  end

  assign start = !busy && ((cmd_q != last_cmd) || hb_fire);

  // last_cmd only moves on a start, so during the tx_done cycle it still holds the
  // byte that just finished; exposing it then makes sent_cmd valid with the pulse.
  assign sent_cmd = tx_done ? last_cmd : sent_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q    <= CMD_STOP;
      last_cmd <= CMD_STOP;
      sent_q   <= CMD_STOP;
    end else begin
      cmd_q <= dir_to_cmd(dir);
      if (start)   last_cmd <= cmd_q;
      if (tx_done) sent_q   <= last_cmd;
    end
  end

`ifdef MOTION_TX_HEARTBEAT_EN
  localparam int HB_CYCLES = HEARTBEAT_MS * (CLK_FREQ / 1000);
  localparam int HB_W      = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;

  logic [HB_W-1:0] hb_cnt;
  logic            hb_due;
  logic            hb_expire;

  // Expiry fires a frame directly when idle; hb_due remembers it across a busy frame.
  assign hb_expire = (hb_cnt == HB_W'(HB_CYCLES - 1));
  assign hb_fire   = hb_due || hb_expire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb_due <= 1'b0;
    end else if (start) begin
      hb_cnt <= '0;
      hb_due <= 1'b0;
    end else begin
      hb_cnt <= hb_expire ? '0 : hb_cnt + HB_W'(1);
      if (hb_expire) hb_due <= 1'b1;
    end
  end
`else
  assign hb_fire = 1'b0;
`endif

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .data (cmd_q),
    .busy (busy),
    .done (tx_done),
    .tx   (uart_tx)
  );

endmodule

// File: tb/tb_motion_cmd_tx.sv
// Bench for motion_cmd_tx: a default-rate instance for the frame timing scenarios and a
// fast-baud instance for the encoder table, randomized traffic and the heartbeat.
`timescale 1ns/1ps
module tb_motion_cmd_tx;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dir_a = '0;
  logic [7:0] dir_b = '0;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [7:0] sent_a, sent_b;
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;

  typedef struct {
    logic [7:0] dirs;
    logic [7:0] cmd;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motion_cmd_tx dut (
    .clk(clk), .rst_n(rst_n),
    .w(dir_a[0]), .s(dir_a[1]), .a(dir_a[2]), .d(dir_a[3]),
    .wa(dir_a[4]), .wd(dir_a[5]), .as(dir_a[6]), .sd(dir_a[7]),
    .uart_tx(tx_a), .busy(busy_a), .tx_done(done_a), .sent_cmd(sent_a)
  );

  motion_cmd_tx #(.CLK_FREQ(1_000_000), .BAUD(115200), .HEARTBEAT_MS(1)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .w(dir_b[0]), .s(dir_b[1]), .a(dir_b[2]), .d(dir_b[3]),
    .wa(dir_b[4]), .wd(dir_b[5]), .as(dir_b[6]), .sd(dir_b[7]),
    .uart_tx(tx_b), .busy(busy_b), .tx_done(done_b), .sent_cmd(sent_b)
  );

  // Highest-priority request wins; request bit order is w,s,a,d,wa,wd,as,sd.
  function automatic logic [7:0] ref_cmd(input logic [7:0] r);
    logic [7:0] codes [8];
    codes = '{8'h01, 8'h04, 8'h02, 8'h08, 8'h03, 8'h09, 8'h06, 8'h0C};
    for (int i = 0; i < 8; i++) if (r[i]) return codes[i];
    return 8'h00;
  endfunction

  function automatic logic line(input bit fast);  return fast ? tx_b   : tx_a;   endfunction
  function automatic logic busyf(input bit fast); return fast ? busy_b : busy_a; endfunction
  function automatic logic donef(input bit fast); return fast ? done_b : done_a; endfunction
  function automatic logic [7:0] sentf(input bit fast); return fast ? sent_b : sent_a; endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for a start bit, then samples every bit near its centre.
  task automatic rx_frame(input bit fast, input int limit, output logic [7:0] b,
                          output bit ok, output int t_start);
    int cpb = fast ? 8 : 434;
    int n = 0;
    ok = 1'b0;
    b = '0;
    t_start = cyc;
    while (line(fast) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (line(fast) !== 1'b0) return;
    t_start = cyc;
    repeat (cpb / 2) @(negedge clk);
    if (line(fast) !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      b[i] = line(fast);
    end
    repeat (cpb) @(negedge clk);
    ok = (line(fast) === 1'b1);
  endtask

  task automatic expect_frame(input bit fast, input int limit, input logic [7:0] exp,
                              input string name, output int t0, output int td);
    logic [7:0] b;
    bit ok;
    int n = 0;
    rx_frame(fast, limit, b, ok, t0);
    check1({name, " frame received"}, ok, 1'b1);
    td = cyc;
    if (!ok) return;
    check8({name, " data"}, b, exp);
    while (donef(fast) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    td = cyc;
    check1({name, " tx_done"}, donef(fast), 1'b1);
    check1({name, " busy low at tx_done"}, busyf(fast), 1'b0);
    check8({name, " sent_cmd"}, sentf(fast), exp);
  endtask

  task automatic expect_quiet(input bit fast, input int ncyc, input string name);
    int bad = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (line(fast) !== 1'b1 || busyf(fast) !== 1'b0 || donef(fast) !== 1'b0) bad++;
    end
    checki({name, " active cycles"}, bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [17];
    logic [7:0] last_model;
    logic [7:0] nd, ex, b;
    bit         ok;
    int         t0, td, t0b, tdb, t1, t2, n;

    vt[0]  = '{8'h01, 8'h01};  vt[1]  = '{8'h02, 8'h04};
    vt[2]  = '{8'h04, 8'h02};  vt[3]  = '{8'h08, 8'h08};
    vt[4]  = '{8'h10, 8'h03};  vt[5]  = '{8'h20, 8'h09};
    vt[6]  = '{8'h40, 8'h06};  vt[7]  = '{8'h80, 8'h0C};
    vt[8]  = '{8'h00, 8'h00};  vt[9]  = '{8'hFF, 8'h01};
    vt[10] = '{8'hFE, 8'h04};  vt[11] = '{8'hFC, 8'h02};
    vt[12] = '{8'hF8, 8'h08};  vt[13] = '{8'hF0, 8'h03};
    vt[14] = '{8'hE0, 8'h09};  vt[15] = '{8'hC0, 8'h06};
    vt[16] = '{8'h81, 8'h01};

    // Reset state, then a long idle with all requests low
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check1("reset uart_tx", tx_a, 1'b1);
    check1("reset busy", busy_a, 1'b0);
    check1("reset tx_done", done_a, 1'b0);
    check8("reset sent_cmd", sent_a, 8'h00);
    rst_n = 1'b1;
    expect_quiet(0, 20000, "idle after reset");

    // Forward: start bit two edges after the request
    dir_a = 8'h01;
    @(negedge clk);
    check1("w line after 1 edge", tx_a, 1'b1);
    @(negedge clk);
    check1("w line after 2 edges", tx_a, 1'b0);
    check1("w busy with start bit", busy_a, 1'b1);
    expect_frame(0, 10, 8'h01, "w", t0, td);
    checki("w frame length", td - t0, 4340);

    // Mid-frame changes: frame stays intact, only the newest command follows
    dir_a = 8'h00;
    expect_frame(0, 10, 8'h00, "release w", t0, td);
    dir_a = 8'h01;
    fork
      expect_frame(0, 10, 8'h01, "w during changes", t0, td);
      begin
        repeat (1500) @(negedge clk);
        dir_a = 8'h40;
        repeat (1500) @(negedge clk);
        dir_a = 8'h80;
      end
    join
    expect_frame(0, 10, 8'h0C, "sd after changes", t0b, tdb);
    checki("back-to-back gap", t0b - td, 1);
    expect_quiet(0, 500, "single follow-up frame");

    // Two requests together: priority winner, then Stop on release
    dir_a = 8'h09;
    expect_frame(0, 10, 8'h01, "w+d", t0, td);
    dir_a = 8'h00;
    expect_frame(0, 10, 8'h00, "release w+d", t0, td);

    // Reset in the middle of a 0x09 frame
    dir_a = 8'h20;
    n = 0;
    while (tx_a !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (434 * 3) @(negedge clk);
    check1("wd busy mid-frame", busy_a, 1'b1);
    check1("wd data bit2 on line", tx_a, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check1("mid-frame reset uart_tx", tx_a, 1'b1);
    check1("mid-frame reset busy", busy_a, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_frame(0, 10, 8'h09, "wd resend after reset", t0, td);

    // Encoder table on the fast instance
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dir_b = vt[i].dirs;
      expect_frame(1, 20, vt[i].cmd, $sformatf("vec%0d", i), t0, td);
    end
    last_model = vt[16].cmd;

`ifndef MOTION_TX_HEARTBEAT_EN
    // Randomized traffic: a frame only when the command differs from the last one sent
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) nd = dir_b;
      else nd = 8'($urandom) & 8'($urandom);
      ex = ref_cmd(nd);
      dir_b = nd;
      if (ex != last_model) begin
        if ($urandom_range(0, 1) == 1) begin
          n = 0;
          while (tx_b !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
          end
          dir_b = 8'($urandom);
          @(negedge clk);
          @(negedge clk);
          dir_b = nd;
        end
        expect_frame(1, 20, ex, $sformatf("random%0d", k), t0, td);
        last_model = ex;
      end
      expect_quiet(1, 30, $sformatf("random%0d no extra frame", k));
    end
`else
    // Heartbeat: with wd held, frames repeat every 1000 cycles start-to-start
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dir_b = 8'h20;
    rx_frame(1, 20, b, ok, t0);
    check1("hb first frame", ok, 1'b1);
    check8("hb first data", b, 8'h09);
    rx_frame(1, 1200, b, ok, t1);
    check1("hb second frame", ok, 1'b1);
    check8("hb second data", b, 8'h09);
    checki("hb period 1", t1 - t0, 1000);
    rx_frame(1, 1200, b, ok, t2);
    check1("hb third frame", ok, 1'b1);
    checki("hb period 2", t2 - t1, 1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motion_cmd_tx.md
# motion_cmd_tx

Encodes the decision tree's current drive direction into the 8-bit motion command byte and sends it to the Arduino as a UART 8N1 frame. It uses the same command byte set that the manual-mode decoder accepts, so both ends of the FPGA–Arduino link share one encoding. A frame goes out only when the encoded command changes, plus an optional periodic heartbeat. The block sits between the decision tree outputs and the Arduino RX pin.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (434 at defaults).
- HEARTBEAT_MS, 100: heartbeat period in ms. Used only when the heartbeat macro is defined.
- clk  in  1  system clock. Single clock domain. Reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- w, s, a, d, wa, wd, as, sd  in  1 each  direction requests: forward, backward, left, right, left-forward, right-forward, left-backward, right-backward.
- uart_tx  out  1  serial line to the Arduino. Idles high.
- busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse in the cycle the stop bit ends.
- sent_cmd  out  8  last command byte fully transmitted.

## Operation
- Encoder (combinational, then registered into cmd_q):
  - Priority order: w=0x01, s=0x04, a=0x02, d=0x08, wa=0x03, wd=0x09, as=0x06, sd=0x0C.
  - No input high gives Stop=0x00.
  - When several inputs are high, the first in the list above wins.
- FSM states and transitions:
  - IDLE: go to START when cmd_q != last_cmd, or when a heartbeat is due. On entry to START, latch cmd_q into shreg and last_cmd.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, CLKS_PER_BIT cycles each. A 3-bit bit index wraps 7→0, then go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then return to IDLE. In the same cycle, pulse tx_done and load sent_cmd from shreg.
- Input changes during a frame:
  - A change does not corrupt the frame; shreg is frozen for the whole frame.
  - On return to IDLE, cmd_q is compared again. Only the latest value is sent; intermediate values are dropped.
  - If cmd_q returns to the in-flight value before the frame ends, no second frame is sent.
- busy = (state != IDLE).
- Reset values:
  - state=IDLE, uart_tx=1, busy=0, tx_done=0.
  - sent_cmd=0x00, last_cmd=0x00, cmd_q=0x00.
  - Baud counter and bit index = 0.
  - No frame is sent after reset while all inputs are low.
- Reset asserted mid-frame: the frame is abandoned and uart_tx returns to 1 at the next edge. last_cmd=0x00, so a non-stop command is resent after release.

## Timing
- Latency: an input change at edge N appears in cmd_q at edge N. The FSM enters START at edge N+1, so uart_tx falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles (4340 at defaults).
- busy rises with the start bit and falls in the same cycle tx_done pulses.
- Back-to-back frames: the earliest next start bit is 1 cycle after tx_done (one IDLE cycle).
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts at each bit boundary. Its width is $clog2(CLKS_PER_BIT).

## Configuration
- MOTION_TX_HEARTBEAT_EN defined:
  - A counter counts HEARTBEAT_MS*(CLK_FREQ/1000) cycles and restarts on every start bit.
  - On expiry it sets hb_due. In IDLE, hb_due forces a frame of cmd_q even if unchanged, then hb_due clears.
  - A change-triggered frame and a heartbeat that fall due in the same cycle produce a single frame.
- Undefined: the heartbeat logic is absent; frames are sent on change only.

## Structure
- motion_pkg holds:
  - The direction enum (Stop, Forward, Backward, Left, Right, Left_forward, Right_forward, Left_backward, Right_backward).
  - The 8-bit command code constants above.
  - Shared with manual_mode so both ends use one encoding.
- Sub-module uart_tx_8n1 (parameter CLKS_PER_BIT) holds the START/DATA/STOP FSM and the baud counter. Interface: start, data[7:0], busy, done, tx.
- The top level contains the encoder, cmd_q, last_cmd, the change compare and the heartbeat counter.

## Test plan
- Reset with all inputs low for 20000 cycles: uart_tx stays 1, busy=0, no tx_done.
- Assert w: start bit after 2 edges; line bits 0,1,0,0,0,0,0,0,0,1. tx_done after 4340 cycles; sent_cmd=0x01.
- Hold w, then switch to as mid-frame and on to sd before the end: the 0x01 frame completes intact. Exactly one next frame follows, 0x0C, starting 1 cycle after tx_done.
- w and d high together: 0x01 is sent. Release both: 0x00 (Stop) is sent.
- Assert rst_n=0 during the DATA bits of 0x09: uart_tx=1 next edge. After release, 0x09 is resent and sent_cmd ends at 0x09.
- With MOTION_TX_HEARTBEAT_EN, CLK_FREQ=1_000_000, HEARTBEAT_MS=1, wd held: a 0x09 frame starts every 1000 cycles, measured start-to-start.
